// File: rtl/fila_pkg.sv
// Shared constants and types for the fila byte queue and its read-side controller.
package fila_pkg;
  localparam int DATA_W     = 8;
  localparam int FILA_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2,
    SETTLE  = 2'd3
  } leitor_state_t;
endpackage

// File: rtl/leitor_fila.sv
// Read-side controller for fila: pops one byte at a time, holds it in a
// single-entry buffer and hands it downstream over valid/ready.
module leitor_fila
  import fila_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              enable_in,
  input  logic [DATA_W-1:0] len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [7:0]        count_out,
  output logic              busy_out
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  leitor_state_t state, next_state;
  logic [3:0]    settle_cnt;
  logic          capture;
  logic          transfer;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable_in && (len_in != '0) && !valid_out) next_state = REQ;
      REQ:     next_state = CAPTURE;
      CAPTURE: next_state = SETTLE;
      SETTLE:  if (settle_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state != IDLE);
    capture  = (state == CAPTURE);
    transfer = valid_out && ready_in;
  end

  // Dedicated flop so the pulse toward the queue never glitches on a
  // multi-bit state change.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      dequeue_out <= 1'b0;
    end else begin
      dequeue_out <= (state == IDLE) && (next_state == REQ);
    end
  end

  // len_in trails the queue shift by a cycle, so SETTLE waits it out.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (capture) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  // Hold register and delivery counter run independently of the FSM.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      count_out <= '0;
    end else begin
      if (capture) begin
        data_out  <= data_in;
        valid_out <= 1'b1;
      end else if (transfer) begin
        valid_out <= 1'b0;
      end
      if (transfer) begin
        count_out <= count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_leitor_fila.sv
// Directed bench for leitor_fila with a behavioural two-phase fila queue model.
module tb_leitor_fila;
  import fila_pkg::*;

  logic       clk_10KHz = 1'b0;
  logic       reset;
  logic       enable_in;
  logic       ready_in;
  logic [7:0] len_in;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] count_out;
  logic       dequeue_out;
  logic       valid_out;
  logic       busy_out;

  logic       enq_req;
  logic [7:0] enq_data;
  logic [7:0] q_mem [FILA_DEPTH];
  int         q_cnt;
  logic       shift_pend;

  int         tests  = 0;
  int         failed = 0;
  int         cyc;
  int         pulses[$];
  logic [7:0] delivered[$];
  bit         underflow_seen;
  bit         idle_bad;
  bit         len_step_bad;
  logic [7:0] last_len;

  always #50 clk_10KHz = ~clk_10KHz;

  leitor_fila #(.SETTLE_CYCLES(2)) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .enable_in  (enable_in),
    .len_in     (len_in),
    .data_in    (data_in),
    .dequeue_out(dequeue_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .count_out  (count_out),
    .busy_out   (busy_out)
  );

  // Queue model: dequeue pulse latches the head, the following edge shifts,
  // and the registered occupancy trails the count by one more edge.
  always @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      q_cnt      <= 0;
      len_in     <= '0;
      data_in    <= '0;
      shift_pend <= 1'b0;
    end else begin
      shift_pend <= dequeue_out && (q_cnt > 0);
      if (dequeue_out && (q_cnt > 0)) data_in <= q_mem[0];
      if (shift_pend) begin
        for (int i = 0; i < FILA_DEPTH - 1; i++) q_mem[i] <= q_mem[i+1];
        q_cnt <= q_cnt - 1;
      end else if (enq_req && (q_cnt < FILA_DEPTH)) begin
        q_mem[q_cnt] <= enq_data;
        q_cnt        <= q_cnt + 1;
      end
      len_in <= 8'(q_cnt);
    end
  end

  function automatic logic [63:0] pack_delivered();
    logic [63:0] acc = '0;
    foreach (delivered[i]) acc = (acc << 8) | 64'(delivered[i]);
    return acc;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    enable_in = 1'b0;
    ready_in  = 1'b0;
    enq_req   = 1'b0;
    enq_data  = '0;
    repeat (2) @(negedge clk_10KHz);
    reset = 1'b0;
    @(negedge clk_10KHz);
    pulses.delete();
    delivered.delete();
    underflow_seen = 0;
    idle_bad       = 0;
    len_step_bad   = 0;
    last_len       = '0;
    cyc            = 0;
  endtask

  task automatic enqueue(input logic [7:0] b);
    enq_req  = 1'b1;
    enq_data = b;
    @(negedge clk_10KHz);
    enq_req  = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_10KHz);
      cyc++;
      if (dequeue_out) begin
        pulses.push_back(cyc);
        if (q_cnt == 0) underflow_seen = 1;
      end
      if (valid_out && ready_in) delivered.push_back(data_out);
      if (dequeue_out || busy_out) idle_bad = 1;
      if (len_in > 8'd8) underflow_seen = 1;
      if ((len_in < last_len) && (len_in != last_len - 8'd1)) len_step_bad = 1;
      last_len = len_in;
    end
  endtask

  task automatic wait_dequeue(output bit seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      run_cycles(1);
      if (dequeue_out) seen = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_in = 1'b0; ready_in = 1'b0; enq_req = 1'b0; enq_data = '0;
    #1;
    tests++;
    if ({dequeue_out, valid_out, busy_out, data_out, count_out} !== 19'd0) begin
      $display("FAIL reset_outputs: got deq=%b val=%b busy=%b data=%h cnt=%h, want all 0",
               dequeue_out, valid_out, busy_out, data_out, count_out);
      failed++;
    end
    do_reset();
    tests++;
    if ({dequeue_out, valid_out, busy_out} !== 3'b000) begin
      $display("FAIL reset_release: got deq=%b val=%b busy=%b, want 000",
               dequeue_out, valid_out, busy_out);
      failed++;
    end
  endtask

  task automatic test_stream();
    do_reset();
    enqueue(8'h11); enqueue(8'h22); enqueue(8'h33);
    repeat (2) @(negedge clk_10KHz);
    last_len  = len_in;
    enable_in = 1'b1;
    ready_in  = 1'b1;
    run_cycles(1);
    tests++;
    if ({dequeue_out, busy_out} !== 2'b11) begin
      $display("FAIL stream_t0: got deq=%b busy=%b, want 11", dequeue_out, busy_out);
      failed++;
    end
    run_cycles(1);
    tests++;
    if ({dequeue_out, valid_out} !== 2'b00) begin
      $display("FAIL stream_t1: got deq=%b val=%b, want 00", dequeue_out, valid_out);
      failed++;
    end
    run_cycles(1);
    tests++;
    if ({valid_out, data_out} !== {1'b1, 8'h11}) begin
      $display("FAIL stream_t2: got val=%b data=%h, want 1 11", valid_out, data_out);
      failed++;
    end
    run_cycles(27);
    tests++;
    if (delivered.size() != 3 || pack_delivered() !== 64'h112233) begin
      $display("FAIL stream_order: got n=%0d bytes=%h, want n=3 bytes=112233",
               delivered.size(), pack_delivered());
      failed++;
    end
    tests++;
    if ({count_out, len_in} !== {8'd3, 8'd0}) begin
      $display("FAIL stream_counts: got cnt=%0d len=%0d, want 3 0", count_out, len_in);
      failed++;
    end
    tests++;
    if (pulses.size() != 3 || (pulses[1] - pulses[0]) != 5 || (pulses[2] - pulses[1]) != 5) begin
      $display("FAIL stream_pulses: got n=%0d at %p, want 3 pulses spaced 5", pulses.size(), pulses);
      failed++;
    end
  endtask

  task automatic test_empty();
    do_reset();
    enable_in = 1'b1;
    ready_in  = 1'b1;
    run_cycles(50);
    tests++;
    if (idle_bad || pulses.size() != 0) begin
      $display("FAIL empty_idle: got activity=%b pulses=%0d, want 0 0", idle_bad, pulses.size());
      failed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    enqueue(8'hA5); enqueue(8'h5A);
    repeat (2) @(negedge clk_10KHz);
    enable_in = 1'b1;
    run_cycles(15);
    tests++;
    if ({valid_out, data_out, len_in} !== {1'b1, 8'hA5, 8'd1} || pulses.size() != 1) begin
      $display("FAIL bp_stall: got val=%b data=%h len=%0d pulses=%0d, want 1 a5 1 1",
               valid_out, data_out, len_in, pulses.size());
      failed++;
    end
    ready_in = 1'b1;
    @(negedge clk_10KHz);
    ready_in = 1'b0;
    tests++;
    if ({count_out, valid_out} !== {8'd1, 1'b0}) begin
      $display("FAIL bp_accept: got cnt=%0d val=%b, want 1 0", count_out, valid_out);
      failed++;
    end
    run_cycles(15);
    tests++;
    if ({valid_out, data_out, len_in} !== {1'b1, 8'h5A, 8'd0} || pulses.size() != 2) begin
      $display("FAIL bp_second: got val=%b data=%h len=%0d pulses=%0d, want 1 5a 0 2",
               valid_out, data_out, len_in, pulses.size());
      failed++;
    end
    tests++;
    if (count_out !== 8'd1) begin
      $display("FAIL bp_count_hold: got %0d, want 1", count_out);
      failed++;
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) enqueue(8'hC0 + 8'(i));
    repeat (2) @(negedge clk_10KHz);
    tests++;
    if (len_in !== 8'd8) begin
      $display("FAIL full_len: got %0d, want 8", len_in);
      failed++;
    end
    last_len  = len_in;
    enable_in = 1'b1;
    ready_in  = 1'b1;
    run_cycles(55);
    tests++;
    if (delivered.size() != 8 || pack_delivered() !== 64'hC0C1C2C3C4C5C6C7) begin
      $display("FAIL full_order: got n=%0d bytes=%h, want n=8 bytes=c0c1c2c3c4c5c6c7",
               delivered.size(), pack_delivered());
      failed++;
    end
    tests++;
    if ({count_out, len_in} !== {8'd8, 8'd0} || pulses.size() != 8) begin
      $display("FAIL full_counts: got cnt=%0d len=%0d pulses=%0d, want 8 0 8",
               count_out, len_in, pulses.size());
      failed++;
    end
    tests++;
    if (underflow_seen || len_step_bad) begin
      $display("FAIL full_len_steps: got underflow=%b bad_step=%b, want 0 0",
               underflow_seen, len_step_bad);
      failed++;
    end
  endtask

  task automatic test_reset_mid_pop();
    bit seen;
    do_reset();
    enqueue(8'h77);
    repeat (2) @(negedge clk_10KHz);
    enable_in = 1'b1;
    ready_in  = 1'b1;
    wait_dequeue(seen);
    tests++;
    if (!seen) begin
      $display("FAIL midpop_start: got no dequeue within 20 cycles, want a pulse");
      failed++;
    end
    @(posedge clk_10KHz);
    #1;
    tests++;
    if (busy_out !== 1'b1) begin
      $display("FAIL midpop_busy: got busy=%b, want 1", busy_out);
      failed++;
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({dequeue_out, valid_out, busy_out, data_out, count_out} !== 19'd0) begin
      $display("FAIL midpop_reset: got deq=%b val=%b busy=%b data=%h cnt=%h, want all 0",
               dequeue_out, valid_out, busy_out, data_out, count_out);
      failed++;
    end
    @(negedge clk_10KHz);
    reset = 1'b0;
    pulses.delete();
    run_cycles(20);
    tests++;
    if (pulses.size() != 0 || len_in !== 8'd0 || busy_out !== 1'b0) begin
      $display("FAIL midpop_after: got pulses=%0d len=%0d busy=%b, want 0 0 0",
               pulses.size(), len_in, busy_out);
      failed++;
    end
  endtask

  task automatic test_enable_drop();
    bit seen;
    do_reset();
    enqueue(8'h3C); enqueue(8'h4D);
    repeat (2) @(negedge clk_10KHz);
    enable_in = 1'b1;
    ready_in  = 1'b1;
    wait_dequeue(seen);
    enable_in = 1'b0;
    run_cycles(20);
    tests++;
    if (!seen || delivered.size() != 1 || pack_delivered() !== 64'h3C) begin
      $display("FAIL endrop_deliver: got seen=%b n=%0d bytes=%h, want 1 1 3c",
               seen, delivered.size(), pack_delivered());
      failed++;
    end
    tests++;
    if (pulses.size() != 1 || {count_out, len_in, busy_out, valid_out} !== {8'd1, 8'd1, 2'b00}) begin
      $display("FAIL endrop_state: got pulses=%0d cnt=%0d len=%0d busy=%b val=%b, want 1 1 1 0 0",
               pulses.size(), count_out, len_in, busy_out, valid_out);
      failed++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_empty();
    test_backpressure();
    test_full();
    test_reset_mid_pop();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
